// File: rtl/rf_read_arbiter.sv
// Round-robin arbiter for the register file's single tristate read bus.
// Define RF_ARB_TURNAROUND_EN to insert a bus-idle TURN cycle after every DRIVE.
module rf_read_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned AW   = 5,
  parameter int unsigned DW   = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] addr,
  output logic [NREQ-1:0]    ack,
  output logic [DW-1:0]      rdata,
  output logic [2**AW-1:0]   bus_en,
  input  logic [DW-1:0]      bus,
  output logic               busy
);

  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned ND = 2**AW;

  typedef enum logic [1:0] {StIdle, StDrive, StTurn} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   grant_q, grant_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [AW-1:0]   raddr_q, raddr_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [DW-1:0]   rdata_q, rdata_d;

  logic [NREQ-1:0]   drive_mask, eligible, elig_rot;
  logic [2*NREQ-1:0] elig_dbl;
  logic              win_vld, arb_go;
  logic [IW-1:0]     win_ofs, win;
  logic [IW:0]       win_sum;
  logic [AW-1:0]     win_addr;

  // The grantee currently on the bus must not win again in the same cycle.
  always_comb begin
    drive_mask = '0;
    if (state_q == StDrive) drive_mask = NREQ'(1) << grant_q;
  end

  assign eligible = req & ~ack_q & ~drive_mask;

  // Rotate so bit 0 is the requester at ptr, then take the lowest set bit.
  assign elig_dbl = {eligible, eligible} >> ptr_q;
  assign elig_rot = elig_dbl[NREQ-1:0];

  always_comb begin
    win_vld = 1'b0;
    win_ofs = '0;
    for (int k = int'(NREQ) - 1; k >= 0; k--) begin
      if (elig_rot[k]) begin
        win_vld = 1'b1;
        win_ofs = IW'(k);
      end
    end
  end

  assign win_sum  = {1'b0, ptr_q} + {1'b0, win_ofs};
  assign win      = (32'(win_sum) >= NREQ) ? IW'(32'(win_sum) - NREQ) : win_sum[IW-1:0];
  assign win_addr = AW'(addr >> (32'(win) * AW));

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    raddr_d = raddr_q;
    ack_d   = '0;
    rdata_d = rdata_q;
    bus_en  = '0;
    arb_go  = 1'b0;

    case (state_q)
      StIdle: arb_go = 1'b1;
      StDrive: begin
        bus_en  = ND'(1) << raddr_q;
        rdata_d = bus;
        ack_d   = NREQ'(1) << grant_q;
`ifdef RF_ARB_TURNAROUND_EN
        state_d = StTurn;
`else
        arb_go  = 1'b1;
`endif
      end
      StTurn:  arb_go = 1'b1;
      default: state_d = StIdle;
    endcase

    if (arb_go) begin
      if (win_vld) begin
        state_d = StDrive;
        grant_d = win;
        raddr_d = win_addr;
        ptr_d   = (32'(win) == NREQ - 1) ? '0 : win + IW'(1);
      end else begin
        state_d = StIdle;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      grant_q <= '0;
      ptr_q   <= '0;
      raddr_q <= '0;
      ack_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      raddr_q <= raddr_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
    end
  end

  assign ack   = ack_q;
  assign rdata = rdata_q;
  assign busy  = (state_q != StIdle);

endmodule

// File: tb/tb_rf_read_arbiter.sv
// Directed and constrained-random bench for rf_read_arbiter; the bus model
// returns 0xDEAD_0000 + register index for whichever driver is enabled.
module tb_rf_read_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned AW   = 5;
  localparam int unsigned DW   = 32;
  localparam int unsigned ND   = 32;
`ifdef RF_ARB_TURNAROUND_EN
  localparam int P = 2;
`else
  localparam int P = 1;
`endif

  logic               clk = 1'b0;
  logic               reset_n;
  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ-1:0]    ack;
  logic [DW-1:0]      rdata;
  logic [ND-1:0]      bus_en;
  logic [DW-1:0]      bus;
  logic               busy;

  logic [AW-1:0] a_arr [NREQ];

  int n_checks = 0;
  int n_errors = 0;

  int unsigned   viol_hot  = 0;
  int unsigned   viol_turn = 0;
  logic [ND-1:0] prev_en   = '0;
  logic [ND-1:0] en_seen   = '0;
  logic [NREQ-1:0] ack_seen = '0;
  bit            log_grants = 1'b0;
  int            grants[$];

  rf_read_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .addr    (addr),
    .ack     (ack),
    .rdata   (rdata),
    .bus_en  (bus_en),
    .bus     (bus),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  always_comb begin
    bus = '0;
    for (int i = 0; i < int'(ND); i++) if (bus_en[i]) bus = 32'hDEAD_0000 | 32'(i);
  end

  always_comb begin
    addr = '0;
    for (int i = 0; i < int'(NREQ); i++) addr[i*AW +: AW] = a_arr[i];
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge and record bus activity.
  task automatic step();
    @(posedge clk);
    #1;
    if ($countones(bus_en) > 1) viol_hot++;
`ifdef RF_ARB_TURNAROUND_EN
    if (prev_en != '0 && bus_en != '0) viol_turn++;
`endif
    prev_en  = bus_en;
    en_seen  = en_seen | bus_en;
    ack_seen = ack_seen | ack;
    if (log_grants) for (int i = 0; i < int'(ND); i++) if (bus_en[i]) grants.push_back(i);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

  initial begin
    int unsigned wait_cnt [NREQ];
    int unsigned max_wait = 0;
    int unsigned spurious = 0;
    logic [ND-1:0] exp_en;
    int g;

    reset_n = 1'b0;
    req     = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      a_arr[i]    = '0;
      wait_cnt[i] = 0;
    end

    repeat (2) step();
    check_eq("rst_bus_en", bus_en, 0);
    check_eq("rst_ack", ack, 0);
    check_eq("rst_rdata", rdata, 0);
    check_eq("rst_busy", busy, 0);
    reset_n = 1'b1;
    step();

    // Contention: all four held, addresses 3..6.
    for (int i = 0; i < int'(NREQ); i++) a_arr[i] = AW'(3 + i);
    req = 4'b1111;
    for (int c = 1; c <= 2 + 4 * P; c++) begin
      step();
      if ((c - 1) % P == 0 && (c - 1) / P <= 4) begin
        g = (c - 1) / P;
        exp_en = ND'(1) << (3 + g % 4);
        check_eq("cont_bus_en", bus_en, exp_en);
      end else begin
        check_eq("cont_bus_idle", bus_en, 0);
      end
      if (c >= 2 && (c - 2) % P == 0 && (c - 2) / P <= 4) begin
        g = (c - 2) / P;
        check_eq("cont_ack", ack, NREQ'(1) << (g % 4));
        check_eq("cont_rdata", rdata, 32'hDEAD_0000 | 32'(3 + g % 4));
      end else begin
        check_eq("cont_ack_zero", ack, 0);
      end
      if (c == 1 + 4 * P) req = '0;
    end
    step();

    // Single read from requester 1.
    a_arr[1] = 5'd7;
    req = 4'b0010;
    step();
    check_eq("single_bus_en", bus_en, 32'h0000_0080);
    check_eq("single_ack_early", ack, 0);
    check_eq("single_busy", busy, 1);
    step();
    check_eq("single_ack", ack, 4'b0010);
    check_eq("single_rdata", rdata, 32'hDEAD_0007);
    check_eq("single_bus_off", bus_en, 0);
    req = '0;
    step();
    check_eq("single_ack_pulse", ack, 0);
    check_eq("single_rdata_hold", rdata, 32'hDEAD_0007);
    check_eq("single_idle", busy, 0);

    // Withdraw: requester 3 pulses while 0 drives and 1 wins the next slot.
    en_seen  = '0;
    ack_seen = '0;
    a_arr[0] = 5'd9;
    req = 4'b0001;
    step();
    check_eq("wd_bus_en", bus_en, 32'h0000_0200);
    a_arr[1] = 5'd17;
    a_arr[3] = 5'd20;
    req = 4'b1011;
    step();
    req = 4'b0010;
    repeat (5) begin
      step();
      if (ack[1]) req[1] = 1'b0;
    end
    check_eq("wd_acks", ack_seen, 4'b0011);
    check_eq("wd_bus_seen", en_seen, 32'h0002_0200);

    // Reset asserted mid-DRIVE.
    a_arr[0] = 5'd5;
    req = 4'b0001;
    step();
    check_eq("rstmid_bus_en", bus_en, 32'h0000_0020);
    ack_seen = '0;
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("rstmid_bus_off", bus_en, 0);
    check_eq("rstmid_busy", busy, 0);
    req = '0;
    repeat (2) step();
    check_eq("rstmid_no_ack", ack_seen, 0);
    check_eq("rstmid_rdata", rdata, 0);

    // Fairness from the reset pointer: 0 and 2 held high.
    reset_n  = 1'b1;
    a_arr[0] = 5'd10;
    a_arr[2] = 5'd12;
    req = 4'b0101;
    grants.delete();
    log_grants = 1'b1;
    repeat (12) step();
    log_grants = 1'b0;
    check_eq("fair_count", grants.size() >= 4, 1);
    for (int k = 0; k < 4; k++) begin
      if (k < grants.size()) check_eq("fair_order", grants[k], (k % 2 == 0) ? 10 : 12);
      else check_eq("fair_order_missing", 0, 1);
    end
    req = '0;
    repeat (4) step();

    // Random traffic; requesters obey the hold-until-ack handshake.
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < int'(NREQ); i++) begin
        if (req[i]) begin
          if (ack[i]) begin
            check_eq("rand_rdata", rdata, 32'hDEAD_0000 | 32'(a_arr[i]));
            wait_cnt[i] = 0;
            if ($urandom_range(1, 0) == 0) req[i] = 1'b0;
            else a_arr[i] = AW'($urandom);
          end else begin
            wait_cnt[i]++;
            if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
          end
        end else begin
          if (ack[i]) spurious++;
          if ($urandom_range(3, 0) == 0) begin
            req[i]   = 1'b1;
            a_arr[i] = AW'($urandom);
          end
        end
      end
      step();
    end

    check_eq("rand_max_wait_ok", max_wait <= 4 * NREQ * P, 1);
    check_eq("rand_spurious_ack", spurious, 0);
    check_eq("onehot_viol", viol_hot, 0);
    check_eq("turn_gap_viol", viol_turn, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rf_read_arbiter.md
# rf_read_arbiter

Shares the register file's single 32-bit read bus among several requesters (decode stage operand fetch, debug port, etc.). The block arbitrates round-robin, decodes the winner's register address into one-hot tristate enables for the per-register 32-bit bus drivers, samples the shared bus, and returns the data with a one-cycle acknowledge. It is the only source of read-enable signals for the register file's read port.

## Interface
- NREQ, 4, number of requesters (2..8)
- AW, 5, register address width; 2**AW bus drivers
- DW, 32, data width
- clk  input  1  clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- req  input  NREQ  per-requester read request, level
- addr  input  NREQ*AW  register address; requester i uses addr[i*AW +: AW]
- ack  output  NREQ  one-cycle pulse; rdata valid for requester i when ack[i]
- rdata  output  DW  registered read data
- bus_en  output  2**AW  one-hot/zero enables to the register drivers
- bus  input  DW  shared tristate read bus
- busy  output  1  high when state is not IDLE

## Operation
- States: IDLE, DRIVE, TURN (TURN exists only with the macro below).
- Eligible set = req & ~ack & ~(grantee while in DRIVE).
- Arbitration: round-robin. Search starts at ptr; ptr resets to 0 and becomes winner+1 (mod NREQ) on every grant.
- IDLE: any eligible requester -> latch grantee and its addr, go DRIVE. Otherwise stay.
- DRIVE: bus_en = one-hot decode of latched addr for exactly this cycle. At the closing edge: rdata <= bus, ack[grantee] <= 1. Next state: DRIVE with new winner if one is eligible, otherwise IDLE (or TURN when the macro is defined).
- TURN: bus_en all zero, no sampling; arbitrate as in IDLE, go DRIVE or IDLE.
- Handshake: requester holds req and addr stable until ack. Dropping req before the grant withdraws it without ack. Once granted, the read completes and acks even if req drops. A requester that keeps req high after ack is re-eligible one cycle after ack.
- Invariant: at most one bus_en bit is high in any cycle. bus_en is zero in IDLE, TURN and reset.
- rdata holds its last value between acks.

## Timing
- Reset (async assert, sync release): state IDLE, bus_en 0, ack 0, rdata 0, busy 0, ptr 0. Assertion mid-DRIVE drops bus_en immediately. The in-flight read is lost with no ack.
- Latency: req sampled in cycle 0 (IDLE) -> DRIVE in cycle 1 -> ack and rdata in cycle 2.
- Throughput without the macro: one read per cycle; bus_en switches driver edge-to-edge.
- ack is registered, never combinational from req.
- Simultaneous ack of one requester and grant of another in the same cycle is legal.

## Configuration
- RF_ARB_TURNAROUND_EN defined: each DRIVE is followed by one TURN cycle with all bus_en low, giving break-before-make between drivers. Peak throughput is one read per 2 cycles, and ack coincides with TURN.
- Undefined: no TURN state; back-to-back DRIVE cycles are allowed.

## Test plan
- Single read: reset, then bus model returns 0xDEAD_0000+reg. req[1]=1, addr1=7 in cycle 0 -> bus_en=1<<7 only in cycle 1; ack=4'b0010, rdata=0xDEAD0007 in cycle 2.
- Contention: req=4'b1111 held, addrs 3,4,5,6 -> grants in order 0,1,2,3,0. Each ack carries the matching data. Check 1 grant/cycle (macro off) or 1 per 2 cycles (macro on).
- Fairness: req[0] and req[2] held high -> grants alternate 0,2,0,2; no requester waits more than NREQ grants.
- Withdraw: req[3] pulses for 1 cycle while requester 0 is in DRIVE -> no ack[3], no bus_en for addr3.
- Reset mid-read: reset_n low during DRIVE -> bus_en 0 within the same cycle, ack never asserts, rdata 0, next grant from requester 0.
- One-hot assertion across random traffic (10k cycles): $countones(bus_en)<=1 every cycle; with the macro, bus_en is zero for one cycle between any two DRIVEs.
